axi_stream_extract_header: RTL and testbench
============================================

AXI_STREAM_EXTRACT_HEADER -- requirements
Module: axi_stream_extract_header

Interface
REQ-001 Parameter DATA_WIDTH, default 32, stream data width in bits.
REQ-002 Parameter DATA_BYTE_WIDTH, default DATA_WIDTH/8, bytes per beat.
REQ-003 Parameter BYTE_CNT_WIDTH, default $clog2(DATA_BYTE_WIDTH), width of header-length field.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 valid_in, data_in[DATA_WIDTH], keep_in[DATA_BYTE_WIDTH], last_in  input  slave stream; ready_in  output  1.
REQ-007 valid_out, data_out[DATA_WIDTH], keep_out[DATA_BYTE_WIDTH], last_out  output  payload master stream; ready_out  input  1.
REQ-008 valid_hdr, data_hdr[DATA_WIDTH], keep_hdr[DATA_BYTE_WIDTH]  output  header side channel; ready_hdr  input  1.
REQ-009 byte_remove_cnt  input  BYTE_CNT_WIDTH  header length minus one (value n means n+1 bytes, 1..DATA_BYTE_WIDTH).

Function
REQ-010 Byte order big-endian; byte 0 = data[DATA_WIDTH-1 -: 8]; keep is MSB-aligned and contiguous (4'b1111, 4'b1110, 4'b1100, 4'b1000).
REQ-011 byte_remove_cnt sampled into register S = n+1 on the first accepted beat of each packet; ignored elsewhere.
REQ-012 States: HEAD (expecting packet first beat), BODY (mid-packet), FLUSH (emitting residual bytes after last_in); reset state HEAD.
REQ-013 HEAD: first beat's top S bytes go to data_hdr right-aligned (LSB side), keep_hdr has S LSBs set; remaining DATA_BYTE_WIDTH-S bytes stored in a carry register.
REQ-014 HEAD->BODY on accepted non-last first beat; HEAD->HEAD on accepted last first beat.
REQ-015 BODY beat: data_out = {carry, top S bytes of data_in}; new carry = low DATA_BYTE_WIDTH-S bytes of data_in; S = DATA_BYTE_WIDTH means pure pass-through, no carry.
REQ-016 Last beat with k valid bytes: if k <= S, emit one beat with carry_cnt+k bytes, last_out=1, go HEAD; if k > S, emit full beat (last_out=0), carry k-S bytes, go FLUSH.
REQ-017 FLUSH: emit carry bytes MSB-aligned, keep per count, last_out=1; ready_in=0; go HEAD on acceptance.
REQ-018 Single-beat packet: payload bytes k-S emitted as one beat with last_out=1 if k > S; none if k = S; if k < S, keep_hdr reflects only the k present bytes and no payload is emitted.
REQ-019 Payload output registered: one-cycle latency from acceptance to valid_out; data/keep/last held stable while valid_out=1 and ready_out=0.
REQ-020 Header output registered: valid_hdr set on first-beat acceptance, held until ready_hdr; header and payload handshakes independent.
REQ-021 ready_in = output register empty or accepted this cycle (ready_out=1), AND state != FLUSH, AND (state != HEAD or header register empty or accepted this cycle).
REQ-022 A BODY beat that produces no output (cannot occur for full-keep non-last beats) is not permitted; non-last beats have full keep_in.
REQ-023 Simultaneous output acceptance and new input acceptance in one cycle sustains full throughput (one beat per cycle).

Reset
REQ-024 rst_n=0 at posedge: state HEAD, valid_out=0, valid_hdr=0, data_out/data_hdr/keep_out/keep_hdr/last_out=0, carry cleared, S=DATA_BYTE_WIDTH.
REQ-025 Reset mid-packet discards partial packet and pending header/payload; first beat after reset is treated as a packet start.

Structure
REQ-026 Package axi_stream_pkg holds DATA_WIDTH default, DATA_BYTE_WIDTH, BYTE_CNT_WIDTH and the state enum (HEAD, BODY, FLUSH).
REQ-027 Combinational sub-module axi_stream_realign merges carry and incoming beat by shift S and returns data, keep and new carry.

Verification
REQ-028 n=1 (S=2), beats 0x0A0B0C0D, 0x01020304, 0x05060708 last keep 1111 -> hdr 0x00000A0B keep 0011; out 0x0C0D0102, 0x03040506, 0x07080000 keep 1100 last.
REQ-029 n=3 (S=4), 3 full beats -> hdr = beat 0 keep 1111; out beats 1,2 unchanged, last on beat 2.
REQ-030 n=0 (S=1), single beat 0xAABBCCDD last keep 1111 -> hdr 0x000000AA keep 0001; out 0xBBCCDD00 keep 1110 last.
REQ-031 n=1, last beat keep 1000 -> final out = carry 2 bytes + 1 byte, keep 1110, last, no FLUSH beat.
REQ-032 ready_out low 5 cycles mid-packet, ready_hdr low 3 cycles -> outputs held stable, ready_in=0, no byte lost or duplicated.
REQ-033 rst_n low for 1 cycle mid-packet -> all valids 0 next cycle; following packet extracted correctly.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared constants and state encoding for the header-extraction stream block.
package axi_stream_pkg;

  localparam int AXIS_DATA_WIDTH      = 32;
  localparam int AXIS_DATA_BYTE_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_BYTE_CNT_WIDTH  = $clog2(AXIS_DATA_BYTE_WIDTH);

  typedef enum logic [1:0] {
    HEAD  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/axi_stream_realign.sv
// Combinational realigner: appends the top `shift` bytes of a beat to an MSB-aligned
// carry and returns the leftover low bytes, shifted up, as the next carry.
module axi_stream_realign
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH      = AXIS_DATA_WIDTH,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int SHIFT_WIDTH     = $clog2(DATA_BYTE_WIDTH) + 1
) (
  input  logic [SHIFT_WIDTH-1:0]     shift,
  input  logic [DATA_WIDTH-1:0]      carry_data,
  input  logic [DATA_BYTE_WIDTH-1:0] carry_keep,
  input  logic [DATA_WIDTH-1:0]      beat_data,
  input  logic [DATA_BYTE_WIDTH-1:0] beat_keep,
  output logic [DATA_WIDTH-1:0]      merged_data,
  output logic [DATA_BYTE_WIDTH-1:0] merged_keep,
  output logic [DATA_WIDTH-1:0]      next_carry_data,
  output logic [DATA_BYTE_WIDTH-1:0] next_carry_keep
);

  logic [DATA_WIDTH-1:0] masked_s;

  // Zero the bytes that keep marks absent so they never leak into outputs.
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < DATA_BYTE_WIDTH; i++) begin
      if (beat_keep[i]) begin
        masked_s[8*i +: 8] = beat_data[8*i +: 8];
      end else begin
        masked_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Keep lanes move exactly like the data bytes, so keep stays MSB-aligned.
  always_comb begin
    merged_data = carry_data | (masked_s >> (8 * (DATA_BYTE_WIDTH - int'(shift))));
    merged_keep = carry_keep | (beat_keep >> (DATA_BYTE_WIDTH - int'(shift)));
    if (int'(shift) >= DATA_BYTE_WIDTH) begin
      next_carry_data = '0;
      next_carry_keep = '0;
    end else begin
      next_carry_data = masked_s << (8 * int'(shift));
      next_carry_keep = beat_keep << int'(shift);
    end
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WIDTH byte header from the front of each packet onto a side
// channel and re-packs the remaining payload into full, MSB-aligned beats.
module axi_stream_extract_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH      = AXIS_DATA_WIDTH,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_out,
  output logic                       valid_hdr,
  output logic [DATA_WIDTH-1:0]      data_hdr,
  output logic [DATA_BYTE_WIDTH-1:0] keep_hdr,
  input  logic                       ready_hdr,
  input  logic [BYTE_CNT_WIDTH-1:0]  byte_remove_cnt
);

  localparam int SW = BYTE_CNT_WIDTH + 1;
  localparam logic [SW-1:0] FULL_SHIFT = SW'(DATA_BYTE_WIDTH);

  state_t                     state_r;
  logic [SW-1:0]              shift_r;
  logic [DATA_WIDTH-1:0]      carry_data_r;
  logic [DATA_BYTE_WIDTH-1:0] carry_keep_r;
  logic                       valid_out_r;
  logic [DATA_WIDTH-1:0]      data_out_r;
  logic [DATA_BYTE_WIDTH-1:0] keep_out_r;
  logic                       last_out_r;
  logic                       valid_hdr_r;
  logic [DATA_WIDTH-1:0]      data_hdr_r;
  logic [DATA_BYTE_WIDTH-1:0] keep_hdr_r;

  logic                       out_free_s;
  logic                       hdr_free_s;
  logic                       ready_in_s;
  logic                       accept_s;
  logic [SW-1:0]              shift_s;
  logic [DATA_WIDTH-1:0]      carry_data_s;
  logic [DATA_BYTE_WIDTH-1:0] carry_keep_s;
  logic [DATA_WIDTH-1:0]      merged_data_s;
  logic [DATA_BYTE_WIDTH-1:0] merged_keep_s;
  logic [DATA_WIDTH-1:0]      next_carry_data_s;
  logic [DATA_BYTE_WIDTH-1:0] next_carry_keep_s;

  // Handshake qualification; in HEAD the shift comes live from byte_remove_cnt.
  always_comb begin
    out_free_s = !valid_out_r || ready_out;
    hdr_free_s = !valid_hdr_r || ready_hdr;
    ready_in_s = out_free_s && (state_r != FLUSH) && ((state_r != HEAD) || hdr_free_s);
    accept_s   = valid_in && ready_in_s;
    if (state_r == HEAD) begin
      shift_s      = {1'b0, byte_remove_cnt} + SW'(1);
      carry_data_s = '0;
      carry_keep_s = '0;
    end else begin
      shift_s      = shift_r;
      carry_data_s = carry_data_r;
      carry_keep_s = carry_keep_r;
    end
  end

  axi_stream_realign #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_BYTE_WIDTH (DATA_BYTE_WIDTH),
    .SHIFT_WIDTH     (SW)
  ) u_realign (
    .shift           (shift_s),
    .carry_data      (carry_data_s),
    .carry_keep      (carry_keep_s),
    .beat_data       (data_in),
    .beat_keep       (keep_in),
    .merged_data     (merged_data_s),
    .merged_keep     (merged_keep_s),
    .next_carry_data (next_carry_data_s),
    .next_carry_keep (next_carry_keep_s)
  );

  // Packet FSM together with the registered payload and header output stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= HEAD;
      shift_r      <= FULL_SHIFT;
      carry_data_r <= '0;
      carry_keep_r <= '0;
      valid_out_r  <= 1'b0;
      data_out_r   <= '0;
      keep_out_r   <= '0;
      last_out_r   <= 1'b0;
      valid_hdr_r  <= 1'b0;
      data_hdr_r   <= '0;
      keep_hdr_r   <= '0;
    end else begin
      if (valid_out_r && ready_out) valid_out_r <= 1'b0;
      if (valid_hdr_r && ready_hdr) valid_hdr_r <= 1'b0;
      case (state_r)
        HEAD: begin
          if (accept_s) begin
            shift_r     <= shift_s;
            valid_hdr_r <= 1'b1;
            data_hdr_r  <= merged_data_s;
            keep_hdr_r  <= merged_keep_s;
            if (!last_in) begin
              carry_data_r <= next_carry_data_s;
              carry_keep_r <= next_carry_keep_s;
              state_r      <= BODY;
            end else begin
              carry_data_r <= '0;
              carry_keep_r <= '0;
              // Single-beat packet: whatever follows the header is the whole payload.
              if (next_carry_keep_s != '0) begin
                valid_out_r <= 1'b1;
                data_out_r  <= next_carry_data_s;
                keep_out_r  <= next_carry_keep_s;
                last_out_r  <= 1'b1;
              end
            end
          end
        end
        BODY: begin
          if (accept_s) begin
            valid_out_r <= 1'b1;
            data_out_r  <= merged_data_s;
            keep_out_r  <= merged_keep_s;
            if (last_in && (next_carry_keep_s == '0)) begin
              last_out_r   <= 1'b1;
              carry_data_r <= '0;
              carry_keep_r <= '0;
              state_r      <= HEAD;
            end else begin
              last_out_r   <= 1'b0;
              carry_data_r <= next_carry_data_s;
              carry_keep_r <= next_carry_keep_s;
              if (last_in) state_r <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (out_free_s) begin
            valid_out_r  <= 1'b1;
            data_out_r   <= carry_data_r;
            keep_out_r   <= carry_keep_r;
            last_out_r   <= 1'b1;
            carry_data_r <= '0;
            carry_keep_r <= '0;
            state_r      <= HEAD;
          end
        end
        default: begin
          state_r <= HEAD;
        end
      endcase
    end
  end

  assign ready_in  = ready_in_s;
  assign valid_out = valid_out_r;
  assign data_out  = data_out_r;
  assign keep_out  = keep_out_r;
  assign last_out  = last_out_r;
  assign valid_hdr = valid_hdr_r;
  assign data_hdr  = data_hdr_r;
  assign keep_hdr  = keep_hdr_r;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header: hand-computed header and payload beats.
module tb_axi_stream_extract_header;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_hdr;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        ready_hdr;
  logic [1:0]  byte_remove_cnt;

  int checks = 0;
  int errors = 0;

  logic [36:0] out_q[$];
  logic [35:0] hdr_q[$];

  axi_stream_extract_header dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_hdr       (valid_hdr),
    .data_hdr        (data_hdr),
    .keep_hdr        (keep_hdr),
    .ready_hdr       (ready_hdr),
    .byte_remove_cnt (byte_remove_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed transfer on both output channels.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) out_q.push_back({data_out, keep_out, last_out});
    if (rst_n && valid_hdr && ready_hdr) hdr_q.push_back({data_hdr, keep_hdr});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int  cyc;
    bit  done;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    valid_in = 1'b1;
    done     = 1'b0;
    cyc      = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (ready_in) done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 1'b0;
    if (!done) chk("send_timeout", 64'(done), 64'(1));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [36:0] obs;
    if (out_q.size() > 0) obs = out_q.pop_front();
    else obs = 'x;
    chk(tag, 64'(obs), 64'({d, k, l}));
  endtask

  task automatic exp_hdr(input string tag, input logic [31:0] d, input logic [3:0] k);
    logic [35:0] obs;
    if (hdr_q.size() > 0) obs = hdr_q.pop_front();
    else obs = 'x;
    chk(tag, 64'(obs), 64'({d, k}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0;
    ready_out = 1'b1; ready_hdr = 1'b1; byte_remove_cnt = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_valid_hdr", 64'(valid_hdr), 64'(0));
    chk("rst_ready_in", 64'(ready_in), 64'(1));
    chk("rst_out_regs", 64'({data_out, keep_out, last_out}), 64'(0));
    chk("rst_hdr_regs", 64'({data_hdr, keep_hdr}), 64'(0));
    @(posedge clk); #1;

    // Header of two bytes, full last beat leaves two bytes for a flush beat.
    byte_remove_cnt = 2'd1;
    send(32'h0A0B0C0D, 4'hF, 1'b0);
    send(32'h01020304, 4'hF, 1'b0);
    send(32'h05060708, 4'hF, 1'b1);
    drain();
    chk("p1_out_count", 64'(out_q.size()), 64'(3));
    chk("p1_hdr_count", 64'(hdr_q.size()), 64'(1));
    exp_hdr("p1_hdr", 32'h00000A0B, 4'b0011);
    exp_out("p1_out0", 32'h0C0D0102, 4'b1111, 1'b0);
    exp_out("p1_out1", 32'h03040506, 4'b1111, 1'b0);
    exp_out("p1_out2", 32'h07080000, 4'b1100, 1'b1);

    // Whole-beat header: payload passes through unchanged.
    byte_remove_cnt = 2'd3;
    send(32'h11223344, 4'hF, 1'b0);
    send(32'h55667788, 4'hF, 1'b0);
    send(32'h99AABBCC, 4'hF, 1'b1);
    drain();
    chk("p2_out_count", 64'(out_q.size()), 64'(2));
    exp_hdr("p2_hdr", 32'h11223344, 4'b1111);
    exp_out("p2_out0", 32'h55667788, 4'b1111, 1'b0);
    exp_out("p2_out1", 32'h99AABBCC, 4'b1111, 1'b1);

    // Single-beat packet with one header byte.
    byte_remove_cnt = 2'd0;
    send(32'hAABBCCDD, 4'hF, 1'b1);
    drain();
    chk("p3_out_count", 64'(out_q.size()), 64'(1));
    exp_hdr("p3_hdr", 32'h000000AA, 4'b0001);
    exp_out("p3_out0", 32'hBBCCDD00, 4'b1110, 1'b1);

    // Short last beat folds into carry: no flush beat.
    byte_remove_cnt = 2'd1;
    send(32'h0A0B0C0D, 4'hF, 1'b0);
    send(32'h01020304, 4'hF, 1'b0);
    send(32'h05060708, 4'b1000, 1'b1);
    drain();
    chk("p4_out_count", 64'(out_q.size()), 64'(2));
    exp_hdr("p4_hdr", 32'h00000A0B, 4'b0011);
    exp_out("p4_out0", 32'h0C0D0102, 4'b1111, 1'b0);
    exp_out("p4_out1", 32'h03040500, 4'b1110, 1'b1);

    // Single beat holding exactly the header: no payload at all.
    send(32'hDEADBEEF, 4'b1100, 1'b1);
    drain();
    chk("p5_out_count", 64'(out_q.size()), 64'(0));
    exp_hdr("p5_hdr", 32'h0000DEAD, 4'b0011);

    // Back-pressure on both outputs while the packet is in flight.
    ready_out = 1'b0;
    ready_hdr = 1'b0;
    fork
      begin
        send(32'h10111213, 4'hF, 1'b0);
        send(32'h14151617, 4'hF, 1'b0);
        send(32'h18191A1B, 4'hF, 1'b0);
        send(32'h1C1D1E1F, 4'hF, 1'b1);
      end
      begin
        cyc = 0;
        while (!valid_out && cyc < 20) begin
          @(negedge clk);
          cyc++;
        end
        chk("stall_valid_seen", 64'(valid_out), 64'(1));
        for (int i = 0; i < 5; i++) begin
          chk("stall_ready_in", 64'(ready_in), 64'(0));
          chk("stall_valid_out", 64'(valid_out), 64'(1));
          chk("stall_data_out", 64'({data_out, keep_out, last_out}), 64'({32'h12131415, 4'hF, 1'b0}));
          if (i < 3) chk("stall_hdr", 64'({valid_hdr, data_hdr, keep_hdr}), 64'({1'b1, 32'h00001011, 4'b0011}));
          if (i == 2) begin
            @(posedge clk);
            #1 ready_hdr = 1'b1;
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();
    chk("p6_out_count", 64'(out_q.size()), 64'(4));
    chk("p6_hdr_count", 64'(hdr_q.size()), 64'(1));
    exp_hdr("p6_hdr", 32'h00001011, 4'b0011);
    exp_out("p6_out0", 32'h12131415, 4'hF, 1'b0);
    exp_out("p6_out1", 32'h16171819, 4'hF, 1'b0);
    exp_out("p6_out2", 32'h1A1B1C1D, 4'hF, 1'b0);
    exp_out("p6_out3", 32'h1E1F0000, 4'b1100, 1'b1);

    // Reset in the middle of a packet, then a fresh packet.
    send(32'hA1A2A3A4, 4'hF, 1'b0);
    send(32'hB1B2B3B4, 4'hF, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid_out", 64'(valid_out), 64'(0));
    chk("mid_rst_valid_hdr", 64'(valid_hdr), 64'(0));
    chk("mid_rst_ready_in", 64'(ready_in), 64'(1));
    out_q.delete();
    hdr_q.delete();
    @(posedge clk); #1;
    byte_remove_cnt = 2'd0;
    send(32'h11223344, 4'hF, 1'b0);
    send(32'h55667788, 4'b1100, 1'b1);
    drain();
    chk("p7_out_count", 64'(out_q.size()), 64'(2));
    exp_hdr("p7_hdr", 32'h00000011, 4'b0001);
    exp_out("p7_out0", 32'h22334455, 4'hF, 1'b0);
    exp_out("p7_out1", 32'h66000000, 4'b1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
